// File: rtl/pwm_timebase_ctrl.sv
// rtl/pwm_timebase_ctrl.sv - PWM timebase controller with shadowed period/mode registers; optional burst mode via TBCTRL_BURST_EN
module pwm_timebase_ctrl (
    input  logic        i_clk,
    input  logic        i_reset_n,
    input  logic        i_wr_en,
    input  logic [1:0]  i_addr,
    input  logic [15:0] i_wdata,
    output logic [15:0] o_rdata,
    input  logic        i_start,
    input  logic        i_stop,
    input  logic [15:0] i_cnt_next,
    output logic        o_cnt_en,
    output logic [1:0]  o_mode,
    output logic [15:0] o_period,
    output logic        o_sync_en,
    output logic        o_busy,
    output logic        o_update_done
);

    typedef enum logic [1:0] {
        ST_IDLE     = 2'b00,
        ST_RUN      = 2'b01,
        ST_STOPPING = 2'b10
    } state_t;

    localparam logic [1:0] ADDR_PERIOD = 2'd0;
    localparam logic [1:0] ADDR_CTRL   = 2'd1;
    localparam logic [1:0] ADDR_BURST  = 2'd2;

    state_t      state;
    state_t      state_nxt;

    logic [15:0] period_sh;
    logic [1:0]  mode_sh;
    logic        sync_sh;
    logic [7:0]  burst_sh;

    logic [15:0] period_act;
    logic [1:0]  mode_act;
    logic        sync_act;

    logic        pending;
    logic        update_done;
    logic        burst_active;
    logic        burst_last;

    logic        wr_period;
    logic        wr_ctrl;
    logic        boundary;
    logic        load_start;
    logic        apply_upd;

    assign wr_period = i_wr_en && (i_addr == ADDR_PERIOD);
    assign wr_ctrl   = i_wr_en && (i_addr == ADDR_CTRL);

    // Boundary: counter is about to restart; mode 00 never restarts
    always_comb begin
        boundary = 1'b0;
        if (o_cnt_en) begin
            case (mode_act)
                2'b01, 2'b11: boundary = (i_cnt_next == 16'd0);
                2'b10:        boundary = (i_cnt_next == period_act);
                default:      boundary = 1'b0;
            endcase
        end
    end

    assign load_start = (state == ST_IDLE) && i_start && !i_stop;
    assign apply_upd  = boundary && pending;

`ifdef TBCTRL_BURST_EN
    logic       wr_burst;
    logic [7:0] burst_cnt;

    assign wr_burst   = i_wr_en && (i_addr == ADDR_BURST);
    assign burst_last = burst_active && (burst_cnt == 8'd1);

    // Burst shadow register
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            burst_sh <= 8'd0;
        end else if (wr_burst) begin
            burst_sh <= i_wdata[7:0];
        end
    end

    // Remaining-period counter: loaded at start, counts RUN boundaries down
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            burst_cnt    <= 8'd0;
            burst_active <= 1'b0;
        end else if (load_start) begin
            burst_cnt    <= burst_sh;
            burst_active <= (burst_sh != 8'd0);
        end else if ((state != ST_IDLE) && (state_nxt == ST_IDLE)) begin
            burst_cnt    <= 8'd0;
            burst_active <= 1'b0;
        end else if ((state == ST_RUN) && boundary && burst_active) begin
            burst_cnt    <= burst_cnt - 8'd1;
        end
    end
`else
    assign burst_sh     = 8'd0;
    assign burst_active = 1'b0;
    assign burst_last   = 1'b0;
`endif

    // Period and control shadow registers, written at any time
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            period_sh <= 16'd0;
            mode_sh   <= 2'b00;
            sync_sh   <= 1'b0;
        end else begin
            if (wr_period) begin
                period_sh <= i_wdata;
            end
            if (wr_ctrl) begin
                mode_sh <= i_wdata[1:0];
                sync_sh <= i_wdata[2];
            end
        end
    end

    // Active registers change only at start or at a boundary with an update pending
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            period_act  <= 16'd0;
            mode_act    <= 2'b00;
            sync_act    <= 1'b0;
            pending     <= 1'b0;
            update_done <= 1'b0;
        end else begin
            update_done <= apply_upd;
            if (load_start || apply_upd) begin
                period_act <= period_sh;
                mode_act   <= mode_sh;
                sync_act   <= sync_sh;
            end
            // A write landing on the boundary keeps pending for the next boundary
            if ((wr_period || wr_ctrl) && (state != ST_IDLE)) begin
                pending <= 1'b1;
            end else if (load_start || apply_upd) begin
                pending <= 1'b0;
            end
        end
    end

    // FSM state register
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // FSM next-state: start wins over a stop in progress, final burst boundary ends the run
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (load_start) begin
                    state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                if (boundary && burst_last) begin
                    state_nxt = ST_IDLE;
                end else if (i_stop) begin
                    state_nxt = ST_STOPPING;
                end
            end
            ST_STOPPING: begin
                if (i_start) begin
                    state_nxt = ST_RUN;
                end else if (boundary) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Combinational register readback
    always_comb begin
        o_rdata = 16'd0;
        case (i_addr)
            2'd0:    o_rdata = period_sh;
            2'd1:    o_rdata = {13'd0, sync_sh, mode_sh};
            2'd2:    o_rdata = {8'd0, burst_sh};
            default: o_rdata = {12'd0, pending, burst_active, state};
        endcase
    end

    assign o_cnt_en      = (state != ST_IDLE);
    assign o_busy        = (state != ST_IDLE);
    assign o_mode        = mode_act;
    assign o_period      = period_act;
    assign o_sync_en     = sync_act;
    assign o_update_done = update_done;

endmodule

// File: tb/tb_pwm_timebase_ctrl.sv
// tb/tb_pwm_timebase_ctrl.sv - directed self-checking bench for pwm_timebase_ctrl
module tb_pwm_timebase_ctrl;

    logic        i_clk;
    logic        i_reset_n;
    logic        i_wr_en;
    logic [1:0]  i_addr;
    logic [15:0] i_wdata;
    logic [15:0] o_rdata;
    logic        i_start;
    logic        i_stop;
    logic [15:0] i_cnt_next;
    logic        o_cnt_en;
    logic [1:0]  o_mode;
    logic [15:0] o_period;
    logic        o_sync_en;
    logic        o_busy;
    logic        o_update_done;

    int n_checks;
    int n_errors;
    int n_bnd;
    int cnt_en_low;

    pwm_timebase_ctrl dut (
        .i_clk         (i_clk),
        .i_reset_n     (i_reset_n),
        .i_wr_en       (i_wr_en),
        .i_addr        (i_addr),
        .i_wdata       (i_wdata),
        .o_rdata       (o_rdata),
        .i_start       (i_start),
        .i_stop        (i_stop),
        .i_cnt_next    (i_cnt_next),
        .o_cnt_en      (o_cnt_en),
        .o_mode        (o_mode),
        .o_period      (o_period),
        .o_sync_en     (o_sync_en),
        .o_busy        (o_busy),
        .o_update_done (o_update_done)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic wr(input logic [1:0] a, input logic [15:0] d);
        i_wr_en = 1'b1;
        i_addr  = a;
        i_wdata = d;
        tick();
        i_wr_en = 1'b0;
    endtask

    task automatic check_reg(input string tag, input logic [1:0] a, input logic [15:0] exp);
        i_addr = a;
        #1;
        check(tag, {16'd0, o_rdata}, {16'd0, exp});
    endtask

    task automatic pulse_start();
        i_start = 1'b1;
        tick();
        i_start = 1'b0;
    endtask

    task automatic pulse_stop();
        i_stop = 1'b1;
        tick();
        i_stop = 1'b0;
    endtask

    initial begin
        n_checks   = 0;
        n_errors   = 0;
        i_reset_n  = 1'b0;
        i_wr_en    = 1'b0;
        i_addr     = 2'd0;
        i_wdata    = 16'd0;
        i_start    = 1'b0;
        i_stop     = 1'b0;
        i_cnt_next = 16'd5;

        // reset state
        tick();
        tick();
        check("rst_cnt_en", {31'd0, o_cnt_en}, 32'd0);
        check("rst_busy", {31'd0, o_busy}, 32'd0);
        check("rst_period", {16'd0, o_period}, 32'd0);
        check_reg("rst_status", 2'd3, 16'h0000);
        i_reset_n = 1'b1;

        // register writes, CTRL masking, STATUS read-only
        wr(2'd1, 16'hFFFF);
        check_reg("ctrl_mask", 2'd1, 16'h0007);
        wr(2'd3, 16'hFFFF);
        check_reg("status_ro", 2'd3, 16'h0000);
        wr(2'd0, 16'd9);
        wr(2'd1, 16'h0005);
        check_reg("period_rb", 2'd0, 16'd9);
        check_reg("ctrl_rb", 2'd1, 16'h0005);
        check("idle_period", {16'd0, o_period}, 32'd0);

        // start applies shadows
        pulse_start();
        check("start_cnt_en", {31'd0, o_cnt_en}, 32'd1);
        check("start_period", {16'd0, o_period}, 32'd9);
        check("start_mode", {30'd0, o_mode}, 32'd1);
        check("start_sync", {31'd0, o_sync_en}, 32'd1);
        check_reg("start_status", 2'd3, 16'h0001);

        // deferred period update at boundary, mode 01
        i_cnt_next = 16'd3;
        wr(2'd0, 16'd4);
        check_reg("pend_status", 2'd3, 16'h0009);
        check("pend_period", {16'd0, o_period}, 32'd9);
        i_cnt_next = 16'd2;
        tick();
        check("pend_period2", {16'd0, o_period}, 32'd9);
        check("pend_upd_lo", {31'd0, o_update_done}, 32'd0);
        i_cnt_next = 16'd0;
        tick();
        check("bnd_period", {16'd0, o_period}, 32'd4);
        check("bnd_upd_hi", {31'd0, o_update_done}, 32'd1);
        check_reg("bnd_status", 2'd3, 16'h0001);
        i_cnt_next = 16'd1;
        tick();
        check("bnd_upd_once", {31'd0, o_update_done}, 32'd0);

        // write coinciding with a boundary: old shadow applied, pending kept
        i_cnt_next = 16'd2;
        wr(2'd0, 16'd6);
        i_cnt_next = 16'd0;
        wr(2'd0, 16'd7);
        check("coin_period", {16'd0, o_period}, 32'd6);
        check_reg("coin_status", 2'd3, 16'h0009);
        tick();
        check("coin_period2", {16'd0, o_period}, 32'd7);
        check_reg("coin_status2", 2'd3, 16'h0001);

        // switch to mode 10 period 5 through a boundary
        i_cnt_next = 16'd3;
        wr(2'd0, 16'd5);
        wr(2'd1, 16'h0002);
        i_cnt_next = 16'd0;
        tick();
        check("m10_mode", {30'd0, o_mode}, 32'd2);
        check("m10_period", {16'd0, o_period}, 32'd5);
        check("m10_sync", {31'd0, o_sync_en}, 32'd0);

        // stop in mode 10 completes at i_cnt_next == period
        i_cnt_next = 16'd3;
        pulse_stop();
        check_reg("stopping_st", 2'd3, 16'h0002);
        i_cnt_next = 16'd4;
        tick();
        check("stopping_busy", {31'd0, o_busy}, 32'd1);
        i_cnt_next = 16'd5;
        #1;
        check("stopping_busy5", {31'd0, o_busy}, 32'd1);
        tick();
        check("stopped_cnt_en", {31'd0, o_cnt_en}, 32'd0);
        check_reg("stopped_status", 2'd3, 16'h0000);

        // stop ignored in IDLE; start with stop stays IDLE
        pulse_stop();
        check_reg("idle_stop", 2'd3, 16'h0000);
        i_start = 1'b1;
        i_stop  = 1'b1;
        tick();
        i_start = 1'b0;
        i_stop  = 1'b0;
        check("idle_startstop", {31'd0, o_cnt_en}, 32'd0);

        // stop then restart from STOPPING
        i_cnt_next = 16'd2;
        cnt_en_low = 0;
        pulse_start();
        if (!o_cnt_en) cnt_en_low++;
        pulse_stop();
        if (!o_cnt_en) cnt_en_low++;
        check_reg("restart_stopping", 2'd3, 16'h0002);
        pulse_start();
        if (!o_cnt_en) cnt_en_low++;
        check_reg("restart_run", 2'd3, 16'h0001);
        tick();
        if (!o_cnt_en) cnt_en_low++;
        check("restart_cnt_en", cnt_en_low, 32'd0);

        // async reset mid-RUN with pending set
        wr(2'd0, 16'd3);
        check_reg("pre_rst_status", 2'd3, 16'h0009);
        i_reset_n = 1'b0;
        #2;
        check("arst_cnt_en", {31'd0, o_cnt_en}, 32'd0);
        check("arst_busy", {31'd0, o_busy}, 32'd0);
        check("arst_period", {16'd0, o_period}, 32'd0);
        check("arst_mode", {30'd0, o_mode}, 32'd0);
        check("arst_sync", {31'd0, o_sync_en}, 32'd0);
        check("arst_upd", {31'd0, o_update_done}, 32'd0);
        tick();
        i_reset_n = 1'b1;
        check_reg("post_rst_status", 2'd3, 16'h0000);
        check_reg("post_rst_period", 2'd0, 16'h0000);

        // burst: BURST=3, mode 01, period 2
        i_cnt_next = 16'd2;
        wr(2'd2, 16'd3);
        wr(2'd1, 16'h0001);
        wr(2'd0, 16'd2);
`ifdef TBCTRL_BURST_EN
        check_reg("burst_rb", 2'd2, 16'd3);
`else
        check_reg("burst_rb", 2'd2, 16'd0);
`endif
        pulse_start();
`ifdef TBCTRL_BURST_EN
        check_reg("burst_status", 2'd3, 16'h0005);
`else
        check_reg("burst_status", 2'd3, 16'h0001);
`endif
        n_bnd = 0;
        for (int i = 0; i < 12; i++) begin
            i_cnt_next = 16'(2 - (i % 3));
            if (o_cnt_en && (i_cnt_next == 16'd0)) n_bnd++;
            tick();
        end
`ifdef TBCTRL_BURST_EN
        check("burst_bnd", n_bnd, 32'd3);
        check("burst_end", {31'd0, o_cnt_en}, 32'd0);
`else
        check("burst_bnd", n_bnd, 32'd4);
        check("burst_end", {31'd0, o_cnt_en}, 32'd1);
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/pwm_timebase_ctrl.md
PWM_TIMEBASE_CTRL -- requirements
Module: pwm_timebase_ctrl

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset: i_clk clocks the block, and i_reset_n is an asynchronous active-low reset.
REQ-002 Ports SHALL be as follows (name, direction, width, meaning):
- i_clk  in  1  clock, rising edge
- i_reset_n  in  1  async active-low reset
- i_wr_en  in  1  register write strobe, single cycle
- i_addr  in  2  register address: 0=PERIOD, 1=CTRL, 2=BURST, 3=STATUS
- i_wdata  in  16  write data
- o_rdata  out  16  combinational readback of the addressed register
- i_start  in  1  start pulse
- i_stop  in  1  stop request pulse
- i_cnt_next  in  16  next value of the driven period counter
- o_cnt_en  out  1  counter count enable
- o_mode  out  2  active counting mode (00 off, 01 up, 10 down, 11 up/down)
- o_period  out  16  active period value
- o_sync_en  out  1  active slave-sync enable
- o_busy  out  1  high when the FSM is not in IDLE
- o_update_done  out  1  one-cycle pulse when the shadow registers are applied at a boundary

Function
REQ-003 The block SHALL hold shadow registers: PERIOD[15:0]; CTRL[1:0]=mode and CTRL[2]=sync_en (CTRL[15:3] read 0); and BURST[7:0]. o_period, o_mode and o_sync_en SHALL be driven from separate active registers.
REQ-004 STATUS SHALL read {12'b0, pending, burst_active, state[1:0]} and SHALL be read-only; writes to address 3 SHALL be ignored.
REQ-005 The boundary SHALL be defined as o_cnt_en=1 and i_cnt_next equal to the restart value: 0 for modes 01 and 11, o_period for mode 10. Mode 00 SHALL never produce a boundary.
REQ-006 The FSM SHALL have the states IDLE(00), RUN(01) and STOPPING(10); o_cnt_en SHALL be 1 in RUN and STOPPING.
REQ-007 IDLE with i_start=1 and i_stop=0 SHALL copy the shadow registers to the active registers, clear pending, and enter RUN; o_cnt_en SHALL rise on the next clock edge.
REQ-008 IDLE with i_start=1 and i_stop=1 SHALL stay in IDLE. i_stop in IDLE SHALL be ignored.
REQ-009 RUN with i_stop=1 SHALL enter STOPPING. STOPPING SHALL enter IDLE at the first boundary, and o_cnt_en SHALL be 0 from the following cycle.
REQ-010 STOPPING with i_start=1 SHALL return to RUN (start has priority). i_start in RUN SHALL be ignored.
REQ-011 A write to PERIOD or CTRL SHALL update the shadow register the next cycle. In RUN or STOPPING it SHALL also set pending.
REQ-012 At a boundary with pending=1, the block SHALL copy the shadow registers to the active registers, clear pending, and pulse o_update_done for one cycle.
REQ-013 When a write coincides with a boundary, the pre-write shadow value SHALL be applied and pending SHALL remain 1.
REQ-014 An applied mode of 00 SHALL hold the counter with no further boundaries; the FSM SHALL stay in its current state until i_stop, reset or a CTRL write followed by i_start from IDLE.
REQ-015 The active registers SHALL never change outside REQ-007 and REQ-012.

Reset
REQ-016 Asserting i_reset_n=0 SHALL immediately clear all of the following to 0: the shadow and active registers, pending, and the burst counter. The FSM SHALL go to IDLE, and o_cnt_en, o_busy and o_update_done SHALL be 0. This SHALL apply mid-operation as well.
REQ-017 Release of reset SHALL be synchronous to i_clk. The first write or start SHALL be accepted on the first edge after release.

Configuration
REQ-018 Macro TBCTRL_BURST_EN SHALL control the burst feature as follows.
- Defined: at start (REQ-007) an 8-bit remaining counter SHALL load BURST. If BURST is non-zero, burst_active=1 and each boundary in RUN decrements the counter. The boundary that reaches 0 SHALL move the FSM to IDLE, exactly like a completed stop. BURST=0 SHALL mean continuous running.
- Undefined: BURST SHALL read 0, writes to it SHALL be ignored, burst_active SHALL be 0, and operation SHALL always be continuous.

Verification
REQ-019 Reset, write PERIOD=9 and CTRL=0x0005, start -> o_period=9, o_mode=01, o_sync_en=1, o_cnt_en=1 one cycle after start.
REQ-020 RUN in mode 01 with period 9, write PERIOD=4 at i_cnt_next=3 -> o_period stays 9 until i_cnt_next=0; at that boundary o_period=4 and o_update_done pulses once.
REQ-021 RUN in mode 10 with period 5, stop at i_cnt_next=3 -> o_busy stays 1 through i_cnt_next=5, then o_cnt_en=0 and state=IDLE.
REQ-022 Stop then start one cycle later while in STOPPING -> state=RUN, o_cnt_en never drops.
REQ-023 With TBCTRL_BURST_EN defined, BURST=3, mode 01, period 2, start -> exactly 3 boundaries, then IDLE. With the macro undefined, the same stimulus -> continuous running, and BURST reads 0.
REQ-024 Assert i_reset_n=0 mid-RUN with pending=1 -> all outputs 0 without waiting for a clock edge; STATUS reads 0 after release.
